game_tick_gen: RTL and testbench
================================

# game_tick_gen

Parametrised game-speed timebase for the game core. It generates the game step clock (square wave plus a one-cycle tick strobe) and a score-increment strobe. Its divisor shrinks on a fixed ramp schedule: fast steps first, then slow steps, saturating at a floor. It adds pause, soft restart, level count and current-divisor visibility, and sits between the board clock and the game FSM / score counter.

## Interface
- CNT_W, 32: width of divisor and all internal counters
- START_DIV, 25000: divisor after reset/restart (cycles per game_clk period)
- MID_DIV, 10000: above this divisor the ramp uses STEP_FAST, at or below uses STEP_SLOW
- MIN_DIV, 2500: divisor floor; must be even, ≥4, ≤START_DIV
- STEP_FAST, 500: divisor decrement per ramp event while div > MID_DIV
- STEP_SLOW, 250: divisor decrement per ramp event while div ≤ MID_DIV
- RAMP_PERIOD, 1000000: enabled cycles between ramp events
- SCORE_MULT, 5: score period = div × SCORE_MULT cycles; 1..255
- LEVEL_W, 4: width of level output
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- enable  in  1  1 = run; 0 = pause (all state frozen)
- restart  in  1  synchronous soft restart to reset state; priority over enable
- game_clk  out  1  game step square wave
- tick  out  1  one-cycle pulse coincident with each game_clk 0→1
- scoreUP  out  1  one-cycle score-increment pulse
- div  out  CNT_W  current divisor
- level  out  LEVEL_W  number of divisor decrements applied, saturating at all-ones
- at_max_speed  out  1  high when div == MIN_DIV

## Operation
- Reset (rst=1 or restart=1): game_clk=0, tick=0, scoreUP=0, div=START_DIV, level=0, half/ramp/score counters=0, at_max_speed=(START_DIV==MIN_DIV).
- enable=0: no counter advances, game_clk/div/level hold, tick=0, scoreUP=0.
- Half counter hc: if hc ≥ (div>>1)−1 then toggle game_clk, hc←0; else hc←hc+1. Half-period = div>>1 cycles.
- tick registered high in the same cycle game_clk becomes 1; otherwise 0.
- Ramp counter rc: if rc == RAMP_PERIOD−1 then rc←0 and a ramp event occurs; else rc←rc+1.
- Ramp event: step = (div > MID_DIV) ? STEP_FAST : STEP_SLOW; div ← (div − step < MIN_DIV, computed without underflow) ? MIN_DIV : div − step. level increments (saturating) only if div actually changed.
- At MIN_DIV rc keeps running; ramp events have no effect.
- Score counter sc: threshold = div × SCORE_MULT computed at CNT_W+8 bits; if sc ≥ threshold−1 then scoreUP←1, sc←0; else sc←sc+1, scoreUP←0.
- Compares use ≥, so a divisor decrease that leaves hc or sc above the new limit fires on the next enabled cycle rather than wrapping.

## Timing
- All outputs registered; no combinational input→output paths.
- The ramp event and hc/sc compares in the same cycle use the old div. The new div takes effect next cycle.
- First game_clk rise and tick at enabled edge (START_DIV>>1) after reset release; period = div cycles for even div.
- restart asserted for one cycle: reset state visible after that edge. The enable value in that cycle is ignored.
- rst clears outputs immediately, without a clock edge.

## Test plan
Parameters for all tests: START_DIV=20, MID_DIV=12, MIN_DIV=6, STEP_FAST=4, STEP_SLOW=2, RAMP_PERIOD=50, SCORE_MULT=2.

- Free run, enable=1: game_clk rises at edge 10, falls at 20, rises at 30. tick is high exactly at edges 10 and 30.
- Ramp: div goes 20→16 at edge 50, →12 at 100, →10 at 150, →8 at 200, →6 at 250 with level=5 and at_max_speed=1. At edge 300 div=6 and level=5 are unchanged.
- Score: scoreUP pulses one cycle at edge 40, then every 40 cycles until edge 50. After that the interval is 32 cycles (16×2).
- Pause: enable=0 for 7 cycles starting at edge 5. game_clk rise moves to edge 17, first scoreUP to edge 47, and the first ramp to edge 57. No tick or scoreUP occurs during the pause.
- Restart at div=8, level=4: on the next edge div=20, level=0, game_clk=0. The next rise follows 10 enabled cycles later.
- Async rst pulsed between edges while game_clk=1: game_clk, tick and scoreUP go to 0 and div goes to 20 before the next clk edge.

Source files
------------

// File: rtl/game_tick_gen.sv
// Game-speed timebase: game step clock, tick strobe and score strobe, with a
// divisor that ramps down on a fixed schedule until it reaches a floor.
module game_tick_gen #(
    parameter int CNT_W       = 32,
    parameter int START_DIV   = 25000,
    parameter int MID_DIV     = 10000,
    parameter int MIN_DIV     = 2500,
    parameter int STEP_FAST   = 500,
    parameter int STEP_SLOW   = 250,
    parameter int RAMP_PERIOD = 1000000,
    parameter int SCORE_MULT  = 5,
    parameter int LEVEL_W     = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               restart,
    output logic               game_clk,
    output logic               tick,
    output logic               scoreUP,
    output logic [CNT_W-1:0]   div,
    output logic [LEVEL_W-1:0] level,
    output logic               at_max_speed
);

    localparam int SC_W = CNT_W + 8;
    localparam logic [CNT_W-1:0] START_V   = CNT_W'(START_DIV);
    localparam logic [CNT_W-1:0] MID_V     = CNT_W'(MID_DIV);
    localparam logic [CNT_W-1:0] MIN_V     = CNT_W'(MIN_DIV);
    localparam logic [CNT_W-1:0] FAST_V    = CNT_W'(STEP_FAST);
    localparam logic [CNT_W-1:0] SLOW_V    = CNT_W'(STEP_SLOW);
    localparam logic [CNT_W-1:0] RAMP_LAST = CNT_W'(RAMP_PERIOD - 1);
    localparam logic             AT_MAX_RST = (START_DIV == MIN_DIV);

    logic               game_clk_q, game_clk_d;
    logic               tick_q, tick_d;
    logic               score_up_q, score_up_d;
    logic [CNT_W-1:0]   div_q, div_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic [CNT_W-1:0]   hc_q, hc_d;
    logic [CNT_W-1:0]   rc_q, rc_d;
    logic [SC_W-1:0]    sc_q, sc_d;
    logic               at_max_q, at_max_d;

    logic [CNT_W-1:0]   half_lim;
    logic [SC_W-1:0]    score_thr;
    logic [CNT_W-1:0]   step_v;
    logic [CNT_W:0]     floor_lim;
    logic [CNT_W-1:0]   div_ramped;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            game_clk_q <= 1'b0;
            tick_q     <= 1'b0;
            score_up_q <= 1'b0;
            div_q      <= START_V;
            level_q    <= '0;
            hc_q       <= '0;
            rc_q       <= '0;
            sc_q       <= '0;
            at_max_q   <= AT_MAX_RST;
        end else begin
            game_clk_q <= game_clk_d;
            tick_q     <= tick_d;
            score_up_q <= score_up_d;
            div_q      <= div_d;
            level_q    <= level_d;
            hc_q       <= hc_d;
            rc_q       <= rc_d;
            sc_q       <= sc_d;
            at_max_q   <= at_max_d;
        end
    end

    always_comb begin
        game_clk_d = game_clk_q;
        tick_d     = 1'b0;
        score_up_d = 1'b0;
        div_d      = div_q;
        level_d    = level_q;
        hc_d       = hc_q;
        rc_d       = rc_q;
        sc_d       = sc_q;
        at_max_d   = at_max_q;

        half_lim   = (div_q >> 1) - CNT_W'(1);
        score_thr  = SC_W'(div_q) * SC_W'(SCORE_MULT);
        step_v     = (div_q > MID_V) ? FAST_V : SLOW_V;
        // Floor test is done one bit wider so a large step cannot wrap below zero.
        floor_lim  = {1'b0, MIN_V} + {1'b0, step_v};
        div_ramped = ({1'b0, div_q} < floor_lim) ? MIN_V : (div_q - step_v);

        if (restart) begin
            game_clk_d = 1'b0;
            div_d      = START_V;
            level_d    = '0;
            hc_d       = '0;
            rc_d       = '0;
            sc_d       = '0;
            at_max_d   = AT_MAX_RST;
        end else if (enable) begin
            if (hc_q >= half_lim) begin
                game_clk_d = ~game_clk_q;
                tick_d     = ~game_clk_q;
                hc_d       = '0;
            end else begin
                hc_d = hc_q + CNT_W'(1);
            end

            if (sc_q >= score_thr - SC_W'(1)) begin
                score_up_d = 1'b1;
                sc_d       = '0;
            end else begin
                sc_d = sc_q + SC_W'(1);
            end

            if (rc_q == RAMP_LAST) begin
                rc_d  = '0;
                div_d = div_ramped;
                if (div_ramped != div_q && level_q != '1) begin
                    level_d = level_q + LEVEL_W'(1);
                end
            end else begin
                rc_d = rc_q + CNT_W'(1);
            end

            at_max_d = (div_d == MIN_V);
        end
    end

    assign game_clk     = game_clk_q;
    assign tick         = tick_q;
    assign scoreUP      = score_up_q;
    assign div          = div_q;
    assign level        = level_q;
    assign at_max_speed = at_max_q;

endmodule

// File: tb/tb_game_tick_gen.sv
// Scoreboard bench for game_tick_gen: stimulus queues expected tick/score edges
// and state snapshots, a monitor pops and compares them as the DUT runs.
module tb_game_tick_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic        restart = 1'b0;
    logic        game_clk;
    logic        tick;
    logic        scoreUP;
    logic [31:0] div;
    logic [3:0]  level;
    logic        at_max_speed;

    game_tick_gen #(
        .CNT_W(32), .START_DIV(20), .MID_DIV(12), .MIN_DIV(6),
        .STEP_FAST(4), .STEP_SLOW(2), .RAMP_PERIOD(50), .SCORE_MULT(2),
        .LEVEL_W(4)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .restart(restart),
        .game_clk(game_clk), .tick(tick), .scoreUP(scoreUP),
        .div(div), .level(level), .at_max_speed(at_max_speed)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          e;
        logic [31:0] div;
        logic [3:0]  level;
        logic        gc_chk;
        logic        gc;
        logic        am;
    } snap_t;

    snap_t snap_q[$];
    int    tick_q[$];
    int    score_q[$];
    snap_t mon_s;
    int    mon_exp;

    int edge_no = 0;
    int tick_lo = 1, tick_hi = 0, score_lo = 1, score_hi = 0;
    int errors = 0, checks = 0;

    // Monitor: counts edges since reset release and consumes expectations.
    always @(posedge clk) begin
        #1;
        if (rst) begin
            edge_no = 0;
        end else begin
            edge_no = edge_no + 1;
            if (tick && edge_no >= tick_lo && edge_no <= tick_hi) begin
                checks++;
                if (tick_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL tick_edge: tick at edge %0d, required no tick", edge_no);
                end else begin
                    mon_exp = tick_q.pop_front();
                    if (mon_exp != edge_no) begin
                        errors++;
                        $display("[TB] FAIL tick_edge: tick at edge %0d, required edge %0d", edge_no, mon_exp);
                    end
                end
            end
            if (scoreUP && edge_no >= score_lo && edge_no <= score_hi) begin
                checks++;
                if (score_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL score_edge: scoreUP at edge %0d, required no pulse", edge_no);
                end else begin
                    mon_exp = score_q.pop_front();
                    if (mon_exp != edge_no) begin
                        errors++;
                        $display("[TB] FAIL score_edge: scoreUP at edge %0d, required edge %0d", edge_no, mon_exp);
                    end
                end
            end
            if (snap_q.size() > 0 && snap_q[0].e == edge_no) begin
                mon_s = snap_q.pop_front();
                checks++;
                if (div !== mon_s.div || level !== mon_s.level || at_max_speed !== mon_s.am ||
                    (mon_s.gc_chk && game_clk !== mon_s.gc)) begin
                    errors++;
                    $display("[TB] FAIL snapshot edge %0d: div=%0d level=%0d game_clk=%b at_max=%b, required div=%0d level=%0d game_clk=%b(chk=%b) at_max=%b",
                             edge_no, div, level, game_clk, at_max_speed,
                             mon_s.div, mon_s.level, mon_s.gc, mon_s.gc_chk, mon_s.am);
                end
            end
        end
    end

    function automatic void add_snap(input int e, input int d, input int l,
                                     input logic chk, input logic gc, input logic am);
        snap_t s;
        s.e = e; s.div = 32'(d); s.level = 4'(l); s.gc_chk = chk; s.gc = gc; s.am = am;
        snap_q.push_back(s);
    endfunction

    task automatic reset_start();
        @(negedge clk);
        rst = 1'b1;
        enable = 1'b1;
        restart = 1'b0;
        tick_q.delete();
        score_q.delete();
        snap_q.delete();
        tick_lo = 1; tick_hi = 0; score_lo = 1; score_hi = 0;
        repeat (2) @(negedge clk);
    endtask

    task automatic reset_release();
        rst = 1'b0;
    endtask

    task automatic run_to(input int n);
        int guard;
        guard = 0;
        while (edge_no < n && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        if (edge_no < n) begin
            checks++;
            errors++;
            $display("[TB] FAIL run_to: reached edge %0d, required edge %0d", edge_no, n);
        end
    endtask

    task automatic check_output(input string name);
        checks++;
        if (game_clk !== 1'b0 || tick !== 1'b0 || scoreUP !== 1'b0 || div !== 32'd20 ||
            level !== 4'd0 || at_max_speed !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s: game_clk=%b tick=%b scoreUP=%b div=%0d level=%0d at_max=%b, required 0 0 0 20 0 0",
                     name, game_clk, tick, scoreUP, div, level, at_max_speed);
        end
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (tick_q.size() != 0 || score_q.size() != 0 || snap_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL %s_drained: pending tick=%0d score=%0d snap=%0d, required 0 0 0",
                     name, tick_q.size(), score_q.size(), snap_q.size());
        end
    endtask

    initial begin
        // Free run covering clock, score and the whole ramp schedule.
        reset_start();
        check_output("reset_state");
        tick_lo = 1; tick_hi = 110; score_lo = 1; score_hi = 110;
        tick_q = '{10, 30, 50, 66, 82, 98, 110};
        score_q = '{40, 72, 101};
        add_snap(9,   20, 0, 1'b1, 1'b0, 1'b0);
        add_snap(10,  20, 0, 1'b1, 1'b1, 1'b0);
        add_snap(20,  20, 0, 1'b1, 1'b0, 1'b0);
        add_snap(30,  20, 0, 1'b1, 1'b1, 1'b0);
        add_snap(50,  16, 1, 1'b1, 1'b1, 1'b0);
        add_snap(100, 12, 2, 1'b0, 1'b0, 1'b0);
        add_snap(150, 10, 3, 1'b0, 1'b0, 1'b0);
        add_snap(200,  8, 4, 1'b0, 1'b0, 1'b0);
        add_snap(249,  8, 4, 1'b0, 1'b0, 1'b0);
        add_snap(250,  6, 5, 1'b0, 1'b0, 1'b1);
        add_snap(300,  6, 5, 1'b0, 1'b0, 1'b1);
        reset_release();
        run_to(305);
        check_drained("free_run");

        // Pause for edges 5..11 shifts every event by 7 edges.
        reset_start();
        tick_lo = 1; tick_hi = 60; score_lo = 1; score_hi = 60;
        tick_q = '{17, 37, 57};
        score_q = '{47};
        add_snap(8,  20, 0, 1'b1, 1'b0, 1'b0);
        add_snap(16, 20, 0, 1'b1, 1'b0, 1'b0);
        add_snap(17, 20, 0, 1'b1, 1'b1, 1'b0);
        add_snap(50, 20, 0, 1'b0, 1'b0, 1'b0);
        add_snap(56, 20, 0, 1'b0, 1'b0, 1'b0);
        add_snap(57, 16, 1, 1'b0, 1'b0, 1'b0);
        reset_release();
        run_to(4);
        enable = 1'b0;
        run_to(11);
        enable = 1'b1;
        run_to(62);
        check_drained("pause");

        // Soft restart at div=8/level=4 with enable low during the restart edge.
        reset_start();
        tick_lo = 210; tick_hi = 225; score_lo = 210; score_hi = 255;
        tick_q = '{220};
        score_q = '{250};
        add_snap(200,  8, 4, 1'b0, 1'b0, 1'b0);
        add_snap(210, 20, 0, 1'b1, 1'b0, 1'b0);
        add_snap(219, 20, 0, 1'b1, 1'b0, 1'b0);
        add_snap(220, 20, 0, 1'b1, 1'b1, 1'b0);
        add_snap(255, 20, 0, 1'b0, 1'b0, 1'b0);
        reset_release();
        run_to(209);
        restart = 1'b1;
        enable = 1'b0;
        run_to(210);
        restart = 1'b0;
        enable = 1'b1;
        run_to(258);
        check_drained("restart");

        // Async reset mid-cycle while game_clk and tick are high after the first ramp.
        reset_start();
        tick_lo = 50; tick_hi = 50;
        tick_q = '{50};
        add_snap(50, 16, 1, 1'b1, 1'b1, 1'b0);
        reset_release();
        run_to(50);
        rst = 1'b1;
        #1;
        check_output("async_rst");
        check_drained("async_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
